alloc_slot_tracker: RTL and testbench
=====================================

// Module: alloc_slot_tracker
// PURPOSE
//   Tracks occupancy of a DEPTH-entry structure (issue queue / ROB / free list) and hands out the
//   lowest-index free slot each cycle. It owns the busy bitmap and drives it, inverted, into a
//   first-one search to pick the grant index. Downstream dispatch consumes alloc_idx. Commit/issue
//   logic returns slots via the free port. Flush clears all slots.
// PARAMETERS
//   DEPTH      16               number of tracked slots (power of two, >=2)
//   IDX_WIDTH  $clog2(DEPTH)    slot index width
//   CNT_WIDTH  IDX_WIDTH+1      width of free_count (holds 0..DEPTH)
// PORTS
//   clk         in   1          single clock, all state on rising edge
//   rst         in   1          synchronous, active-high reset
//   flush       in   1          clear all busy bits (pipeline squash)
//   alloc_req   in   1          dispatch requests one slot this cycle
//   alloc_gnt   out  1          request granted this cycle (combinational)
//   alloc_idx   out  IDX_WIDTH  granted slot = lowest-index free slot
//   free_valid  in   1          release one slot this cycle
//   free_idx    in   IDX_WIDTH  slot being released
//   busy_vec    out  DEPTH      registered occupancy bitmap, bit i = slot i busy
//   free_count  out  CNT_WIDTH  registered number of free slots
//   full        out  1          free_count == 0 (registered)
//   empty       out  1          free_count == DEPTH (registered)
// BEHAVIOUR
//   - Reset (rst=1 at edge): busy_vec=0, free_count=DEPTH, full=0, empty=1; overrides all inputs.
//   - Search: has_free = |~busy_vec. alloc_idx = index of lowest set bit of ~busy_vec.
//     alloc_idx = 0 when no slot is free.
//   - Grant: alloc_gnt = alloc_req & has_free & ~flush & ~rst. Same-cycle combinational.
//     Handshake is req/gnt. An ungranted req is dropped, not queued. Requester re-asserts.
//   - On gnt: busy_vec[alloc_idx] <= 1 at the next edge. Latency 1 cycle to busy_vec/count.
//   - Free: if free_valid & busy_vec[free_idx], then busy_vec[free_idx] <= 0 at the next edge.
//     Freeing an already-free slot is ignored: no state or count change.
//   - Simultaneous alloc+free: both take effect. The freed slot is not a grant candidate that cycle
//     because search uses the current registered bitmap. free_count net change is 0.
//   - free_count next = free_count - gnt + valid_free. Never under/overflows by construction.
//     full/empty are derived from the next count and registered with it.
//   - Flush: at the next edge busy_vec=0, free_count=DEPTH, full=0, empty=1.
//     Same-cycle alloc and free are discarded.
//   - Precedence: rst > flush > {alloc, free}.
//   - Full boundary: with DEPTH slots busy, alloc_gnt=0 even if free_valid is high the same cycle.
//   - Mid-operation reset: behaves exactly like power-on reset; any in-flight grant that cycle is
//     suppressed.
//   - Structure: registers busy_vec and free_count only. Search is combinational
//     (priority encoder, LSB first).
// TESTING
//   1. Reset, then alloc_req=1 for 3 cycles -> alloc_idx 0,1,2; gnt=1 each;
//      busy_vec=16'h0007, free_count=13.
//   2. Busy=16'h0007, free_idx=1 -> busy=16'h0005. Next alloc -> idx=1, busy=16'h0007.
//   3. Fill all 16 -> full=1, free_count=0, alloc_gnt=0.
//      Same cycle alloc_req + free_idx=5 -> gnt=0; next cycle gnt=1, idx=5.
//   4. Busy=16'h000F, alloc_req + free_idx=2 same cycle -> idx=4; busy=16'h001B, count unchanged at 12.
//   5. Free already-free slot 9 with busy=16'h0003 -> busy and free_count (14) unchanged.
//   6. Busy=16'hFF00, flush with alloc_req+free_valid -> gnt=0; next cycle busy=0, count=16, empty=1.
//      Repeat with rst mid-fill -> same result.

Source files
------------

// File: rtl/alloc_slot_tracker.sv
// Slot occupancy tracker: keeps a busy bitmap and free count, and grants the
// lowest-index free slot each cycle through an LSB-first priority search.
module alloc_slot_tracker #(
  parameter int DEPTH     = 16,
  parameter int IDX_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH = IDX_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [IDX_WIDTH-1:0] alloc_idx,
  input  logic                 free_valid,
  input  logic [IDX_WIDTH-1:0] free_idx,
  output logic [DEPTH-1:0]     busy_vec,
  output logic [CNT_WIDTH-1:0] free_count,
  output logic                 full,
  output logic                 empty
);

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;

  logic [DEPTH-1:0]     free_vec;
  logic                 has_free;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 free_ok;

  // Search runs on the registered bitmap, so a slot freed this cycle is not
  // a candidate until the next one.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    free_vec = ~busy_q;
    has_free = |free_vec;
    pick_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) pick_idx = IDX_WIDTH'(i);
    end
  end

  assign alloc_gnt = alloc_req & has_free & ~flush & ~rst;
  assign alloc_idx = pick_idx;
  assign free_ok   = free_valid & busy_q[free_idx];

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (flush) begin
      busy_d  = '0;
      count_d = CNT_WIDTH'(DEPTH);
    end else begin
      if (alloc_gnt) busy_d[pick_idx] = 1'b1;
      if (free_ok)   busy_d[free_idx] = 1'b0;
      count_d = count_q - CNT_WIDTH'(alloc_gnt) + CNT_WIDTH'(free_ok);
    end
    full_d  = (count_d == '0);
    empty_d = (count_d == CNT_WIDTH'(DEPTH));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      busy_q  <= '0;
      count_q <= CNT_WIDTH'(DEPTH);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign busy_vec   = busy_q;
  assign free_count = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_alloc_slot_tracker.sv
// Directed bench for alloc_slot_tracker: a behavioural slot model pushes the
// expected grant and next state to a scoreboard queue as each step is driven.
module tb_alloc_slot_tracker;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [3:0]  alloc_idx;
  logic        free_valid;
  logic [3:0]  free_idx;
  logic [15:0] busy_vec;
  logic [4:0]  free_count;
  logic        full;
  logic        empty;

  alloc_slot_tracker #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx  (alloc_idx),
    .free_valid (free_valid),
    .free_idx   (free_idx),
    .busy_vec   (busy_vec),
    .free_count (free_count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        gnt;
    logic [3:0]  idx;
    logic [15:0] busy;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_busy;
  int          m_cnt;
  int          n_cmp;
  int          n_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check the combinational
  // grant mid-cycle, check the registered state just after the rising edge.
  task automatic step(input string tag, input logic req, input logic fv,
                      input logic [3:0] fi, input logic fl, input logic r);
    exp_t e;
    logic has_free;
    logic vfree;
    @(negedge clk);
    alloc_req  = req;
    free_valid = fv;
    free_idx   = fi;
    flush      = fl;
    rst        = r;

    has_free = (m_busy != 16'hFFFF);
    e.tag = tag;
    e.idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (!m_busy[i]) e.idx = 4'(i);
    e.gnt = req & has_free & ~fl & ~r;
    vfree = fv & m_busy[fi];
    if (r || fl) begin
      e.busy = 16'h0000;
      e.cnt  = DEPTH;
    end else begin
      e.busy = m_busy;
      if (e.gnt) e.busy[e.idx] = 1'b1;
      if (vfree) e.busy[fi] = 1'b0;
      e.cnt = m_cnt - int'(e.gnt) + int'(vfree);
    end
    sb.push_back(e);

    #1;
    check({tag, "_gnt"}, 32'(alloc_gnt), 32'(sb[0].gnt));
    check({tag, "_idx"}, 32'(alloc_idx), 32'(sb[0].idx));

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_busy"},  32'(busy_vec),   32'(e.busy));
    check({e.tag, "_count"}, 32'(free_count), 32'(e.cnt));
    check({e.tag, "_full"},  32'(full),       32'(e.cnt == 0));
    check({e.tag, "_empty"}, 32'(empty),      32'(e.cnt == DEPTH));
    m_busy = e.busy;
    m_cnt  = e.cnt;
  endtask

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_idx   = 4'd0;

    @(posedge clk);
    #1;
    check("reset_busy",  32'(busy_vec),   32'h0);
    check("reset_count", 32'(free_count), 32'd16);
    check("reset_full",  32'(full),       32'd0);
    check("reset_empty", 32'(empty),      32'd1);
    check("reset_idx",   32'(alloc_idx),  32'd0);
    rst    = 1'b0;
    m_busy = 16'h0000;
    m_cnt  = DEPTH;

    // Three back-to-back allocations.
    step("t1_a0", 1, 0, 0, 0, 0);
    step("t1_a1", 1, 0, 0, 0, 0);
    step("t1_a2", 1, 0, 0, 0, 0);
    check("t1_busy_const",  32'(busy_vec),   32'h0007);
    check("t1_count_const", 32'(free_count), 32'd13);

    // Free a middle slot, then re-allocate it.
    step("t2_free1", 0, 1, 4'd1, 0, 0);
    check("t2_busy_after_free", 32'(busy_vec), 32'h0005);
    step("t2_realloc", 1, 0, 0, 0, 0);
    check("t2_busy_after_alloc", 32'(busy_vec), 32'h0007);

    // Fill to the top, then alloc while freeing slot 5 at the full boundary.
    for (int i = 0; i < 13; i++) step("t3_fill", 1, 0, 0, 0, 0);
    check("t3_full_const", 32'(full), 32'd1);
    step("t3_full_alloc_free5", 1, 1, 4'd5, 0, 0);
    step("t3_regrant5", 1, 0, 0, 0, 0);
    check("t3_busy_const", 32'(busy_vec), 32'hFFFF);

    // Simultaneous alloc and free from 16'h000F.
    step("t4_flush", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("t4_fill", 1, 0, 0, 0, 0);
    step("t4_alloc_free2", 1, 1, 4'd2, 0, 0);
    check("t4_busy_const",  32'(busy_vec),   32'h001B);
    check("t4_count_const", 32'(free_count), 32'd12);

    // Freeing an already-free slot is ignored.
    step("t5_flush", 0, 0, 0, 1, 0);
    step("t5_fill", 1, 0, 0, 0, 0);
    step("t5_fill", 1, 0, 0, 0, 0);
    step("t5_free9", 0, 1, 4'd9, 0, 0);
    check("t5_busy_const",  32'(busy_vec),   32'h0003);
    check("t5_count_const", 32'(free_count), 32'd14);

    // Build 16'hFF00, then flush with alloc and free both requested.
    step("t6_flush", 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step("t6_fill", 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("t6_drain", 0, 1, 4'(i), 0, 0);
    check("t6_busy_ff00", 32'(busy_vec), 32'hFF00);
    step("t6_flush_req", 1, 1, 4'd8, 1, 0);
    check("t6_flush_busy",  32'(busy_vec),   32'h0000);
    check("t6_flush_count", 32'(free_count), 32'd16);
    check("t6_flush_empty", 32'(empty),      32'd1);

    // Reset in the middle of filling, with a request pending.
    for (int i = 0; i < 5; i++) step("t6_refill", 1, 0, 0, 0, 0);
    step("t6_rst_req", 1, 1, 4'd2, 0, 1);
    check("t6_rst_busy",  32'(busy_vec),   32'h0000);
    check("t6_rst_count", 32'(free_count), 32'd16);
    check("t6_rst_empty", 32'(empty),      32'd1);
    step("t6_post_rst", 1, 0, 0, 0, 0);

    @(negedge clk);
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    flush      = 1'b0;
    rst        = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
